// File: rtl/median_result_packer.sv
// Packs the 1-bit filtered pixel stream into bytes, writes them to the result RAM, then drains the RAM onto a valid/ready byte stream.
// Optional: define PACK_PIXEL_COUNT_EN to add the fgCount foreground-pixel counter output.
module median_result_packer #(
  parameter int unsigned IMG_W   = 256,
  parameter int unsigned IMG_H   = 256,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned BYTE_AW = 13
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               pixIn,
  input  logic               pixValid,
  input  logic [ADDR_W-1:0]  xPixAddr,
  input  logic [ADDR_W-1:0]  yPixAddr,
  input  logic               filterDone,
  output logic [BYTE_AW-1:0] memWrAddr,
  output logic [7:0]         memWrData,
  output logic               memWe,
  output logic [BYTE_AW-1:0] memRdAddr,
  input  logic [7:0]         memRdData,
  output logic [7:0]         outByte,
  output logic               outValid,
  input  logic               outReady,
  output logic               packBusy,
  output logic               packDone,
`ifdef PACK_PIXEL_COUNT_EN
  output logic [16:0]        fgCount,
`endif
  output logic               seqError
);

  localparam int unsigned IDX_W   = 2 * ADDR_W + 1;
  localparam int unsigned N_BYTES = IMG_W * IMG_H / 8;
  localparam logic [BYTE_AW-1:0] LAST_ADDR = BYTE_AW'(N_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_COLLECT, S_FLUSH, S_RD_REQ, S_RD_WAIT, S_HOLD, S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [7:0]         shift_q, shift_d;
  logic [7:0]         mask_q, mask_d;
  logic [BYTE_AW-1:0] cur_byte_q, cur_byte_d;
  logic [IDX_W-1:0]   exp_idx_q, exp_idx_d;
  logic               seq_err_q, seq_err_d;
  logic [BYTE_AW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]         wr_data_q, wr_data_d;
  logic               we_q, we_d;
  logic [BYTE_AW-1:0] rd_addr_q, rd_addr_d;
  logic [7:0]         out_byte_q, out_byte_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;
  logic               pack_done_q, pack_done_d;
`ifdef PACK_PIXEL_COUNT_EN
  logic [16:0]        fg_q, fg_d;
`endif

  logic [IDX_W-1:0]   pix_idx_c;
  logic [BYTE_AW-1:0] pix_byte_c;
  logic [2:0]         bit_pos_c;
  logic [7:0]         bit_oh_c;
  logic [7:0]         pix_bit_c;
  logic [7:0]         merged_c;

  assign pix_idx_c  = IDX_W'(yPixAddr) * IDX_W'(IMG_W) + IDX_W'(xPixAddr);
  assign pix_byte_c = BYTE_AW'(pix_idx_c >> 3);
  assign bit_pos_c  = xPixAddr[2:0];
  assign bit_oh_c   = 8'b1 << bit_pos_c;
  assign pix_bit_c  = pixIn ? bit_oh_c : 8'h00;
  assign merged_c   = shift_q | pix_bit_c;

  // Next-state and datapath
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    mask_d      = mask_q;
    cur_byte_d  = cur_byte_q;
    exp_idx_d   = exp_idx_q;
    seq_err_d   = seq_err_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    we_d        = 1'b0;
    rd_addr_d   = rd_addr_q;
    out_byte_d  = out_byte_q;
    out_valid_d = out_valid_q;
    pack_done_d = 1'b0;
`ifdef PACK_PIXEL_COUNT_EN
    fg_d        = fg_q;
`endif

    // A pixel outside the collect window is dropped but flagged
    if (pixValid && state_q != S_COLLECT) seq_err_d = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        shift_d    = 8'h00;
        mask_d     = 8'h00;
        exp_idx_d  = '0;
        cur_byte_d = '0;
        if (start) begin
          state_d   = S_COLLECT;
          seq_err_d = 1'b0;
`ifdef PACK_PIXEL_COUNT_EN
          fg_d      = 17'd0;
`endif
        end
      end
      S_COLLECT: begin
        if (pixValid) begin
          if (pix_idx_c != exp_idx_q) seq_err_d = 1'b1;
          exp_idx_d  = pix_idx_c + IDX_W'(1);
          cur_byte_d = pix_byte_c;
`ifdef PACK_PIXEL_COUNT_EN
          if (pixIn) fg_d = fg_q + 17'd1;
`endif
          if (pix_byte_c != cur_byte_q && mask_q != 8'h00) begin
            // Jumped to a new byte: retire the partial one first
            we_d      = 1'b1;
            wr_addr_d = cur_byte_q;
            wr_data_d = shift_q;
            shift_d   = pix_bit_c;
            mask_d    = bit_oh_c;
          end else if (bit_pos_c == 3'd7) begin
            we_d      = 1'b1;
            wr_addr_d = pix_byte_c;
            wr_data_d = merged_c;
            shift_d   = 8'h00;
            mask_d    = 8'h00;
          end else begin
            shift_d = merged_c;
            mask_d  = mask_q | bit_oh_c;
          end
        end
        if (filterDone) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        if (mask_q != 8'h00) begin
          we_d      = 1'b1;
          wr_addr_d = cur_byte_q;
          wr_data_d = shift_q;
          shift_d   = 8'h00;
          mask_d    = 8'h00;
        end else begin
          state_d   = S_RD_REQ;
          rd_addr_d = '0;
        end
      end
      S_RD_REQ: state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        out_byte_d  = memRdData;
        out_valid_d = 1'b1;
        state_d     = S_HOLD;
      end
      S_HOLD: begin
        if (outReady) begin
          out_valid_d = 1'b0;
          if (rd_addr_q == LAST_ADDR) begin
            state_d     = S_DONE;
            pack_done_d = 1'b1;
          end else begin
            rd_addr_d = rd_addr_q + BYTE_AW'(1);
            state_d   = S_RD_REQ;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      shift_q     <= 8'h00;
      mask_q      <= 8'h00;
      cur_byte_q  <= '0;
      exp_idx_q   <= '0;
      seq_err_q   <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= 8'h00;
      we_q        <= 1'b0;
      rd_addr_q   <= '0;
      out_byte_q  <= 8'h00;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      pack_done_q <= 1'b0;
`ifdef PACK_PIXEL_COUNT_EN
      fg_q        <= 17'd0;
`endif
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      mask_q      <= mask_d;
      cur_byte_q  <= cur_byte_d;
      exp_idx_q   <= exp_idx_d;
      seq_err_q   <= seq_err_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      we_q        <= we_d;
      rd_addr_q   <= rd_addr_d;
      out_byte_q  <= out_byte_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      pack_done_q <= pack_done_d;
`ifdef PACK_PIXEL_COUNT_EN
      fg_q        <= fg_d;
`endif
    end
  end

  assign memWrAddr = wr_addr_q;
  assign memWrData = wr_data_q;
  assign memWe     = we_q;
  assign memRdAddr = rd_addr_q;
  assign outByte   = out_byte_q;
  assign outValid  = out_valid_q;
  assign packBusy  = busy_q;
  assign packDone  = pack_done_q;
  assign seqError  = seq_err_q;
`ifdef PACK_PIXEL_COUNT_EN
  assign fgCount   = fg_q;
`endif

endmodule

// File: tb/tb_median_result_packer.sv
// Directed bench for median_result_packer on a 256x12 frame with a behavioural result RAM.
module tb_median_result_packer;

  localparam int unsigned IMG_W = 256;
  localparam int unsigned IMG_H = 12;
  localparam int NPIX = IMG_W * IMG_H;
  localparam int NB   = NPIX / 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        pix_in = 1'b0;
  logic        pix_valid = 1'b0;
  logic [7:0]  x_pix = 8'd0;
  logic [7:0]  y_pix = 8'd0;
  logic        filter_done = 1'b0;
  logic [12:0] mem_wr_addr;
  logic [7:0]  mem_wr_data;
  logic        mem_we;
  logic [12:0] mem_rd_addr;
  logic [7:0]  mem_rd_data = 8'h00;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        pack_busy;
  logic        pack_done;
  logic        seq_error;
`ifdef PACK_PIXEL_COUNT_EN
  logic [16:0] fg_count;
`endif

  median_result_packer #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(8), .BYTE_AW(13)) dut (
    .clk(clk), .reset(reset), .start(start), .pixIn(pix_in), .pixValid(pix_valid),
    .xPixAddr(x_pix), .yPixAddr(y_pix), .filterDone(filter_done),
    .memWrAddr(mem_wr_addr), .memWrData(mem_wr_data), .memWe(mem_we),
    .memRdAddr(mem_rd_addr), .memRdData(mem_rd_data),
    .outByte(out_byte), .outValid(out_valid), .outReady(out_ready),
    .packBusy(pack_busy), .packDone(pack_done),
`ifdef PACK_PIXEL_COUNT_EN
    .fgCount(fg_count),
`endif
    .seqError(seq_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] ram [0:8191];
  always @(posedge clk) begin
    if (mem_we) ram[mem_wr_addr] <= mem_wr_data;
    mem_rd_data <= ram[mem_rd_addr];
  end

  // Write / stream / done logs, appended only here
  logic [12:0] wr_addr_log[$];
  logic [7:0]  wr_data_log[$];
  int          wr_cyc_log[$];
  logic [7:0]  rx_log[$];
  int          done_cnt = 0;
  always @(negedge clk) begin
    if (reset) begin
      if (mem_we) begin
        wr_addr_log.push_back(mem_wr_addr);
        wr_data_log.push_back(mem_wr_data);
        wr_cyc_log.push_back(cyc);
      end
      if (out_valid && out_ready) rx_log.push_back(out_byte);
      if (pack_done) done_cnt = done_cnt + 1;
    end
  end

  int n_chk = 0;
  int n_pass = 0;
  int wr_base, rx_base, done_base;
  int pix7_cyc;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic mark();
    wr_base   = wr_addr_log.size();
    rx_base   = rx_log.size();
    done_base = done_cnt;
  endtask

  task automatic start_frame();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // mode 0: all ones, mode 1: pixIn = x[0]; skip < 0 means no gap
  task automatic drive_pixels(input int mode, input int last, input int skip);
    for (int i = 0; i <= last; i++) begin
      int x;
      if (i == skip) continue;
      x = i % IMG_W;
      x_pix       = 8'(x);
      y_pix       = 8'(i / IMG_W);
      pix_in      = (mode == 1) ? x[0] : 1'b1;
      pix_valid   = 1'b1;
      filter_done = (i == last);
      if (i == 7) pix7_cyc = cyc;
      if (skip >= 0 && i == skip + 1) chk("D_seq_pre", 64'(seq_error), 64'(0));
      @(posedge clk); #1;
      if (skip >= 0 && i == skip + 1) chk("D_seq_rise", 64'(seq_error), 64'(1));
    end
    pix_valid   = 1'b0;
    filter_done = 1'b0;
    pix_in      = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int k = 0; k < 6000 && done_cnt == done_base; k++) @(negedge clk);
    chk({tag, "_done_cnt"}, 64'(done_cnt - done_base), 64'(1));
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_writes(input string tag, input int exp_cnt, input logic [7:0] exp_data);
    int bad = 0;
    chk({tag, "_wr_cnt"}, 64'(wr_addr_log.size() - wr_base), 64'(exp_cnt));
    for (int i = wr_base; i < wr_addr_log.size(); i++)
      if (wr_addr_log[i] != 13'(i - wr_base) || wr_data_log[i] != exp_data) bad++;
    chk({tag, "_wr_bad"}, 64'(bad), 64'(0));
  endtask

  task automatic check_stream(input string tag, input int exp_cnt, input logic [7:0] exp_byte);
    int bad = 0;
    chk({tag, "_rx_cnt"}, 64'(rx_log.size() - rx_base), 64'(exp_cnt));
    for (int i = rx_base; i < rx_log.size(); i++)
      if (rx_log[i] != exp_byte) bad++;
    chk({tag, "_rx_bad"}, 64'(bad), 64'(0));
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({mem_wr_addr, mem_wr_data, mem_we, mem_rd_addr, out_byte,
                out_valid, pack_busy, pack_done, seq_error});
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0]  b0;
    logic [12:0] a0;
    int changes;
    int k;

    #12;
    chk("reset_outs", all_outs(), 64'(0));
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    chk("idle_busy", 64'(pack_busy), 64'(0));

    // A: all-ones raster frame
    out_ready = 1'b1;
    mark();
    start_frame();
    chk("A_busy", 64'(pack_busy), 64'(1));
    drive_pixels(0, NPIX - 1, -1);
    wait_done("A");
    check_writes("A", NB, 8'hFF);
    check_stream("A", NB, 8'hFF);
    chk("A_seq", 64'(seq_error), 64'(0));
    chk("A_idle", 64'(pack_busy), 64'(0));
`ifdef PACK_PIXEL_COUNT_EN
    chk("A_fg", 64'(fg_count), 64'(NPIX));
`endif

    // B: alternating pixels, byte = 0xAA, write one cycle after x=7
    mark();
    start_frame();
    drive_pixels(1, NPIX - 1, -1);
    wait_done("B");
    check_writes("B", NB, 8'hAA);
    chk("B_wr_lat", 64'(wr_cyc_log[wr_base]), 64'(pix7_cyc + 1));
    check_stream("B", NB, 8'hAA);

    // C: frame ends after pixel x=2 -> partial flush 0x07
    mark();
    start_frame();
    drive_pixels(0, 2, -1);
    wait_done("C");
    chk("C_wr_cnt", 64'(wr_addr_log.size() - wr_base), 64'(1));
    chk("C_wr_addr", 64'(wr_addr_log[wr_base]), 64'(0));
    chk("C_wr_data", 64'(wr_data_log[wr_base]), 64'(8'h07));
    chk("C_rx_cnt", 64'(rx_log.size() - rx_base), 64'(NB));
    chk("C_rx0", 64'(rx_log[rx_base]), 64'(8'h07));

    // D: pixel (5,10) missing
    mark();
    start_frame();
    drive_pixels(0, NPIX - 1, 10 * IMG_W + 5);
    wait_done("D");
    chk("D_wr_cnt", 64'(wr_addr_log.size() - wr_base), 64'(NB));
    chk("D_wr_addr", 64'(wr_addr_log[wr_base + 320]), 64'(320));
    chk("D_wr_data", 64'(wr_data_log[wr_base + 320]), 64'(8'hDF));
    chk("D_rx320", 64'(rx_log[rx_base + 320]), 64'(8'hDF));
    chk("D_seq_sticky", 64'(seq_error), 64'(1));

    // E: backpressure on the first byte
    out_ready = 1'b0;
    mark();
    start_frame();
    chk("E_seq_clr", 64'(seq_error), 64'(0));
    drive_pixels(0, NPIX - 1, -1);
    for (k = 0; k < 2000 && !out_valid; k++) @(negedge clk);
    chk("E_valid", 64'(out_valid), 64'(1));
    b0 = out_byte;
    a0 = mem_rd_addr;
    changes = 0;
    repeat (20) begin
      @(negedge clk);
      if (!out_valid || out_byte != b0 || mem_rd_addr != a0) changes++;
    end
    chk("E_stable", 64'(changes), 64'(0));
    chk("E_hold_addr", 64'(a0), 64'(0));
    chk("E_no_xfer", 64'(rx_log.size() - rx_base), 64'(0));
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("E_one_xfer", 64'(rx_log.size() - rx_base), 64'(1));
    chk("E_valid_drop", 64'(out_valid), 64'(0));
    repeat (10) @(posedge clk);
    #1;
    chk("E_still_one", 64'(rx_log.size() - rx_base), 64'(1));
    chk("E_next_addr", 64'(mem_rd_addr), 64'(1));
    chk("E_next_valid", 64'(out_valid), 64'(1));
    out_ready = 1'b1;
    wait_done("E");
    check_stream("E", NB, 8'hFF);

    // F: reset while in RD_WAIT
    mark();
    start_frame();
    drive_pixels(0, NPIX - 1, -1);
    for (k = 0; k < 2000 && !(out_valid && out_ready); k++) @(negedge clk);
    chk("F_first_xfer", 64'(out_valid && out_ready), 64'(1));
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("F_reset_outs", all_outs(), 64'(0));
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    chk("F_idle", 64'(pack_busy), 64'(0));

    // G: clean frame after the abort
    mark();
    start_frame();
    drive_pixels(0, NPIX - 1, -1);
    wait_done("G");
    check_writes("G", NB, 8'hFF);
    check_stream("G", NB, 8'hFF);
    chk("G_seq", 64'(seq_error), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/median_result_packer.md
Name: median_result_packer

Overview:
- Downstream stage of filteringModule. Consumes the 1-bit filtered pixel stream (dataOut/writeEnable with xMedianAddress/yMedianAddress) and packs 8 horizontally adjacent pixels into one byte.
- Writes each packed byte to a result RAM.
- After filterDone, reads the RAM back sequentially and presents the bytes on a valid/ready byte stream to the transmit stage.

Parameters:
- IMG_W, 256: image width in pixels. Must be a multiple of 8.
- IMG_H, 256: image height in pixels.
- ADDR_W, 8: width of the x/y pixel address inputs.
- BYTE_AW, 13: result RAM address width. Must satisfy 2^BYTE_AW >= IMG_W*IMG_H/8.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- start  in  1  one-cycle pulse (the same pulse that starts the filter) that begins a frame.
- pixIn  in  1  filtered pixel (filter dataOut).
- pixValid  in  1  pixel strobe (filter writeEnable).
- xPixAddr  in  ADDR_W  pixel column (xMedianAddress).
- yPixAddr  in  ADDR_W  pixel row (yMedianAddress).
- filterDone  in  1  one-cycle pulse marking the end of the filtered frame.
- memWrAddr  out  BYTE_AW  RAM write address.
- memWrData  out  8  RAM write data.
- memWe  out  1  RAM write strobe.
- memRdAddr  out  BYTE_AW  RAM read address.
- memRdData  in  8  RAM read data; valid 1 cycle after memRdAddr.
- outByte  out  8  stream data.
- outValid  out  1  stream valid.
- outReady  in  1  stream ready from the consumer.
- packBusy  out  1  high in every state except IDLE.
- packDone  out  1  one-cycle pulse after the last byte is accepted.
- seqError  out  1  sticky flag: a pixel arrived out of raster order.

Behaviour:
- Reset (async assert, synchronous release):
  - All outputs go to 0, and state goes to IDLE.
  - Internal shift byte = 0, byte-valid mask = 0, expected index = 0.
- Pixel index: idx = yPixAddr*IMG_W + xPixAddr.
  - Byte address = idx>>3; bit position = xPixAddr[2:0].
  - Bit 0 holds the leftmost pixel of the byte.
- States: IDLE, COLLECT, FLUSH, RD_REQ, RD_WAIT, HOLD, DONE.
- IDLE:
  - start -> COLLECT.
  - Clear the shift byte, mask, expected index and seqError.
- COLLECT, on each pixValid cycle:
  - If idx != expected index, set seqError (sticky for the frame).
  - If the byte address differs from the current accumulating byte and the mask is non-zero, first write the current byte (missing bits are 0), then start the new byte with this pixel.
  - Otherwise set the bit at the pixel's bit position; expected index = idx+1.
  - When the bit position is 7, write the byte in the cycle after the pixel: memWe=1 for exactly 1 cycle, mask cleared. Write latency is 1 cycle from the 8th pixel.
  - filterDone -> FLUSH. If filterDone and pixValid coincide, the pixel is accepted first.
- FLUSH:
  - If mask != 0, write the partial byte (memWe for 1 cycle).
  - Then -> RD_REQ with the read address set to 0.
- RD_REQ: drive memRdAddr, then -> RD_WAIT.
- RD_WAIT: capture memRdData into outByte, assert outValid, then -> HOLD.
- HOLD:
  - outByte and outValid stay stable until outReady=1.
  - On acceptance: if the address is IMG_W*IMG_H/8-1 -> DONE; otherwise address+1 -> RD_REQ.
  - outValid drops in the cycle after acceptance.
  - Throughput is 1 byte per 3 cycles with outReady held high.
- DONE: pulse packDone for 1 cycle, then -> IDLE.
- start outside IDLE is ignored.
- filterDone outside COLLECT is ignored.
- pixValid outside COLLECT is dropped and sets seqError.
- Reset mid-frame aborts immediately; RAM contents are undefined for that frame.
- memWe is never high in the RD_*, HOLD or DONE states.

Optional Feature:
- Macro: PACK_PIXEL_COUNT_EN.
- Defined:
  - Adds output port fgCount, width 17 (covers the default 256x256 frame of 65536 pixels).
  - The count clears on start and increments on each accepted pixValid with pixIn=1.
  - It holds its value after DONE until the next start. Reset value is 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Raster frame, all pixels 1, outReady=1:
  - 8192 writes, each with memWrData=8'hFF, and memWrAddr 0..8191 in order.
  - 8192 stream bytes = 8'hFF, then one packDone pulse; seqError=0.
- Alternating pattern, pixIn = x[0] on row 0:
  - Byte 0 = 8'hAA, and memWe lands 1 cycle after pixel x=7.
- filterDone after pixel (x=2,y=0) only, pixels 1:
  - FLUSH writes addr 0, data 8'h07.
  - The drain then still streams all 8192 bytes.
- Skip pixel (x=5,y=10):
  - seqError rises on pixel x=6 and stays high.
  - Byte at addr 10*32+0 = 8'hDF (bit 5 = 0).
- Backpressure: outReady low for 20 cycles during HOLD.
  - outByte and outValid stay constant; no address advance.
  - Exactly one transfer on release.
- Reset asserted during RD_WAIT:
  - All outputs are 0 asynchronously; state is IDLE after release.
  - A new start runs a clean frame with seqError=0.
